stage1_delay_difference: RTL
============================

STAGE1_DELAY_DIFFERENCE -- requirements
Module: stage1_delay_difference

Interface
REQ-001 SHALL have parameter DATA_W, default 14, the signed input sample width.
REQ-002 SHALL have parameter OUT_W, default 22, the signed output width, matching the downstream integral-stage input.
REQ-003 SHALL have parameter DEPTH, default 64, the delay-line depth in samples (power of two).
REQ-004 SHALL have port SYS_CLK, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port RESET, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port DATAIN, input, DATA_W bits: signed input sample x(n).
REQ-007 SHALL have port DATAIN_VALID, input, 1 bit: DATAIN is a sample this cycle.
REQ-008 SHALL have port K_LEN, input, 6 bits: rise delay k, latched only on CFG_LOAD.
REQ-009 SHALL have port L_LEN, input, 6 bits: delay l, latched only on CFG_LOAD.
REQ-010 SHALL have port CFG_LOAD, input, 1 bit: single-cycle pulse that latches the config and restarts the stage.
REQ-011 SHALL have port DATAOUT, output, OUT_W bits: signed d(n), sign-extended.
REQ-012 SHALL have port DATAOUT_VALID, output, 1 bit: DATAOUT is valid this cycle.
REQ-013 SHALL have port RUN, output, 1 bit: high in state RUN (delay line full).
REQ-014 SHALL have port CFG_ERR, output, 1 bit: high in state ERR.

Function
REQ-015 SHALL compute d(n) = x(n) - x(n-k) - x(n-l) + x(n-k-l) exactly in DATA_W+2 bits, then sign-extend it to OUT_W; no saturation is needed.
REQ-016 SHALL store samples in a circular buffer of DEPTH entries.
- Write pointer advances by one per accepted sample, mod DEPTH.
- Tap addresses are (wptr - j) mod DEPTH for j in {k, l, k+l}.
REQ-017 SHALL have a 2-stage pipeline: DATAOUT_VALID asserts exactly 2 cycles after the cycle an accepted DATAIN_VALID is sampled; back-to-back samples every cycle are sustained; there is no backpressure.
REQ-018 SHALL keep a fill counter that saturates at k+l; a tap x(n-j) SHALL be treated as 0 while fewer than j samples have been stored since restart.
REQ-019 SHALL implement an FSM with states IDLE, FILL, RUN, ERR.
- IDLE -> FILL on the first accepted sample, or directly to RUN if the fill is then complete.
- FILL -> RUN when the fill count reaches k+l.
- RUN holds until CFG_LOAD or RESET.
REQ-020 SHALL process samples (with DATAOUT_VALID following) in IDLE, FILL and RUN.
REQ-021 SHALL, in ERR, ignore samples and never assert DATAOUT_VALID.
REQ-022 SHALL treat a config as valid only if 1 <= k <= l and k+l <= DEPTH-1.
REQ-023 SHALL, on CFG_LOAD with a valid config:
- latch K_LEN/L_LEN;
- clear the fill counter and write pointer;
- clear both pipeline valid flags;
- go to IDLE.
REQ-024 SHALL, on CFG_LOAD with an invalid config, go to ERR, keep the previous k/l unused, and clear the pipeline.
REQ-025 SHALL give CFG_LOAD priority over a simultaneous DATAIN_VALID: that sample is dropped.
REQ-026 SHALL hold DATAOUT at its last value when DATAOUT_VALID is low.

Reset
REQ-027 SHALL, on RESET high at a clock edge:
- set DATAOUT=0, DATAOUT_VALID=0, RUN=0, CFG_ERR=0;
- set state IDLE;
- set k=8, l=16;
- clear the write pointer and fill counter;
- discard in-flight pipeline data.
REQ-028 SHALL give RESET priority over CFG_LOAD and DATAIN_VALID in the same cycle.
REQ-029 SHALL not require clearing buffer contents on reset; the fill masking of REQ-018 guarantees zero history.

Verification
REQ-030 SHALL cover, after reset with default k=8, l=16, a step input 0 -> 1000 held: DATAOUT = 1000 for samples 0-7, 0 for 8-15, -1000 for 16-23, 0 from 24; RUN rises after sample 23 is accepted.
REQ-031 SHALL cover k=3, l=5 and a single 500 impulse followed by zeros: DATAOUT is +500 at offset 0, -500 at offsets 3 and 5, +500 at offset 8, and 0 elsewhere; latency is 2 cycles.
REQ-032 SHALL cover k=l=1 with inputs 8191, -8192, 8191: the third output is 32766, correctly sign-extended; an alternating pattern never overflows.
REQ-033 SHALL cover CFG_LOAD with k=40, l=30: CFG_ERR=1 and 10 following samples produce no DATAOUT_VALID; a valid CFG_LOAD (4, 4) clears CFG_ERR and restarts in IDLE.
REQ-034 SHALL cover CFG_LOAD together with DATAIN_VALID during RUN: that sample is dropped, no output appears for the 2 in-flight samples, and the next output uses zero history.
REQ-035 SHALL cover wrap-around with k=20, l=43 and ramp x(n)=n for 200 continuous samples: DATAOUT = 0 for every n >= 63; RESET mid-stream clears all outputs the next cycle and restarts from IDLE.

Source files
------------

// File: rtl/stage1_delay_difference.sv
// First stage of a delay-difference (trapezoidal-shaper style) filter:
// d(n) = x(n) - x(n-k) - x(n-l) + x(n-k-l) over a circular sample buffer, two-cycle pipeline.
module stage1_delay_difference #(
  parameter int DATA_W = 14,
  parameter int OUT_W  = 22,
  parameter int DEPTH  = 64
) (
  input  logic              SYS_CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] DATAIN,
  input  logic              DATAIN_VALID,
  input  logic [5:0]        K_LEN,
  input  logic [5:0]        L_LEN,
  input  logic              CFG_LOAD,
  output logic [OUT_W-1:0]  DATAOUT,
  output logic              DATAOUT_VALID,
  output logic              RUN,
  output logic              CFG_ERR
);

  localparam int AW    = $clog2(DEPTH);
  localparam int SUM_W = DATA_W + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t state;

  logic [5:0]    k_len;
  logic [5:0]    l_len;
  logic [6:0]    kl_sum;
  logic [6:0]    fill_cnt;
  logic [AW-1:0] wptr;

  logic signed [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0] addr_k;
  logic [AW-1:0] addr_l;
  logic [AW-1:0] addr_kl;

  logic signed [DATA_W-1:0] tap_k;
  logic signed [DATA_W-1:0] tap_l;
  logic signed [DATA_W-1:0] tap_kl;

  logic signed [DATA_W-1:0] s1_x;
  logic signed [DATA_W-1:0] s1_xk;
  logic signed [DATA_W-1:0] s1_xl;
  logic signed [DATA_W-1:0] s1_xkl;
  logic                     s1_valid;

  logic signed [SUM_W-1:0]  diff;
  logic [OUT_W-1:0]         diff_ext;

  logic [6:0] cfg_sum;
  logic       cfg_ok;
  logic       accept;
  logic       fill_done_next;

  function automatic logic signed [SUM_W-1:0] sext(input logic signed [DATA_W-1:0] v);
    return {{(SUM_W-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  assign kl_sum  = {1'b0, k_len} + {1'b0, l_len};
  assign cfg_sum = {1'b0, K_LEN} + {1'b0, L_LEN};
  assign cfg_ok  = (K_LEN != 6'd0) && (K_LEN <= L_LEN) && (32'(cfg_sum) <= DEPTH - 1);

  // A sample is taken only when neither reset nor a config load claims the cycle.
  assign accept         = DATAIN_VALID && !CFG_LOAD && (state != S_ERR);
  assign fill_done_next = (fill_cnt + 7'd1) >= kl_sum;

  // Taps never collide with the write slot because k+l < DEPTH.
  assign addr_k  = wptr - AW'(k_len);
  assign addr_l  = wptr - AW'(l_len);
  assign addr_kl = wptr - AW'(kl_sum);

  // History older than the samples stored since restart reads as zero.
  assign tap_k  = (fill_cnt >= {1'b0, k_len}) ? mem[addr_k]  : '0;
  assign tap_l  = (fill_cnt >= {1'b0, l_len}) ? mem[addr_l]  : '0;
  assign tap_kl = (fill_cnt >= kl_sum)        ? mem[addr_kl] : '0;

  assign diff     = sext(s1_x) - sext(s1_xk) - sext(s1_xl) + sext(s1_xkl);
  assign diff_ext = {{(OUT_W-SUM_W){diff[SUM_W-1]}}, diff};

  // NOTE: the sample buffer and stage-1 data carry no reset; the fill mask
  // already hides stale contents, and leaving them unreset keeps the buffer in plain RAM.
  always_ff @(posedge SYS_CLK) begin
    if (accept && !RESET) begin
      mem[wptr] <= DATAIN;
      s1_x      <= DATAIN;
      s1_xk     <= tap_k;
      s1_xl     <= tap_l;
      s1_xkl    <= tap_kl;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge SYS_CLK) begin
    if (RESET) begin
      state         <= S_IDLE;
      k_len         <= 6'd8;
      l_len         <= 6'd16;
      wptr          <= '0;
      fill_cnt      <= '0;
      s1_valid      <= 1'b0;
      DATAOUT       <= '0;
      DATAOUT_VALID <= 1'b0;
      RUN           <= 1'b0;
      CFG_ERR       <= 1'b0;
    end else if (CFG_LOAD) begin
      s1_valid      <= 1'b0;
      DATAOUT_VALID <= 1'b0;
      RUN           <= 1'b0;
      if (cfg_ok) begin
        k_len    <= K_LEN;
        l_len    <= L_LEN;
        wptr     <= '0;
        fill_cnt <= '0;
        state    <= S_IDLE;
        CFG_ERR  <= 1'b0;
      end else begin
        state   <= S_ERR;
        CFG_ERR <= 1'b1;
      end
    end else begin
      s1_valid      <= accept;
      DATAOUT_VALID <= s1_valid;
      if (s1_valid) begin
        DATAOUT <= diff_ext;
      end
      if (accept) begin
        wptr <= wptr + AW'(1);
        if (fill_cnt < kl_sum) begin
          fill_cnt <= fill_cnt + 7'd1;
        end
        case (state)
          S_IDLE, S_FILL: begin
            if (fill_done_next) begin
              state <= S_RUN;
              RUN   <= 1'b1;
            end else begin
              state <= S_FILL;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
